simmem_release_scheduler: RTL and testbench

// Per-slot countdown scheduler for the write-response bank. Accepts (slot, delay) pairs when
// a write address is handshaked. Counts each delay down, and releases expired slots to the

---
 rtl/simmem_pkg.sv | 16 +
 rtl/simmem_rr_arbiter.sv | 37 +++
 rtl/simmem_release_scheduler.sv | 130 +++++++++++++
 tb/tb_simmem_release_scheduler.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simmem_pkg.sv
// Shared sizing constants and slot lifecycle encoding for the write-response
// release path of the memory simulator.
package simmem_pkg;

  localparam int WriteRespBankCapacity  = 16;
  localparam int WriteRespBankAddrWidth = $clog2(WriteRespBankCapacity);
  localparam int DelayWidth             = 8;

  typedef enum logic [1:0] {
    SlotIdle,
    SlotCounting,
    SlotExpired,
    SlotGranted
  } slot_state_e;

endpackage

// File: rtl/simmem_rr_arbiter.sv
// Combinational round-robin picker: the first requester at or above ptr wins,
// wrapping modulo N.
module simmem_rr_arbiter #(
  parameter int N = simmem_pkg::WriteRespBankCapacity
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt_onehot,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_valid
);

  localparam int IdxWidth = $clog2(N);

  // The sum is one bit wider so the modulo also holds when N is not a power of two.
  logic [IdxWidth:0]   sum;
  logic [IdxWidth-1:0] cand;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    gnt_valid  = 1'b0;
    sum        = '0;
    cand       = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IdxWidth+1)'(k);
      if (sum >= (IdxWidth+1)'(N)) sum = sum - (IdxWidth+1)'(N);
      cand = sum[IdxWidth-1:0];
      if (!gnt_valid && req[cand]) begin
        gnt_valid        = 1'b1;
        gnt_idx          = cand;
        gnt_onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/simmem_release_scheduler.sv
// Per-slot countdown scheduler: counts each accepted delay down, then releases
// expired slots to the response bank one at a time in round-robin order.
module simmem_release_scheduler
  import simmem_pkg::*;
#(
  parameter int NumSlots   = WriteRespBankCapacity,
  parameter int SlotWidth  = WriteRespBankAddrWidth,
  parameter int DelayWidth = simmem_pkg::DelayWidth
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  sched_valid_i,
  output logic                  sched_ready_o,
  input  logic [SlotWidth-1:0]  sched_slot_i,
  input  logic [DelayWidth-1:0] sched_delay_i,
  output logic [NumSlots-1:0]   release_en_o,
  input  logic [NumSlots-1:0]   released_onehot_i,
  output logic [NumSlots-1:0]   slot_busy_o,
  output logic                  err_o
);

  slot_state_e           state_q [NumSlots];
  slot_state_e           state_d [NumSlots];
  logic [DelayWidth-1:0] cnt_q   [NumSlots];
  logic [DelayWidth-1:0] cnt_d   [NumSlots];

  logic [NumSlots-1:0]  release_en_q;
  logic [SlotWidth-1:0] rr_ptr_q;
  logic                 err_q;

  logic [NumSlots-1:0]  expired_vec;
  logic [NumSlots-1:0]  gnt_onehot;
  logic [SlotWidth-1:0] gnt_idx;
  logic                 gnt_valid;
  logic                 ack;
  logic                 arb_en;
  logic                 accept;

  // The grant register is one-hot, so masking the acknowledge with it isolates the granted slot.
  assign ack    = |(release_en_q & released_onehot_i);
  assign arb_en = !(|release_en_q) || ack;
  assign accept = sched_valid_i && sched_ready_o;

  always_comb begin
    sched_ready_o = 1'b0;
    slot_busy_o   = '0;
    expired_vec   = '0;
    for (int i = 0; i < NumSlots; i++) begin
      slot_busy_o[i] = (state_q[i] != SlotIdle);
      expired_vec[i] = (state_q[i] == SlotExpired);
      if (sched_slot_i == SlotWidth'(i) && state_q[i] == SlotIdle) sched_ready_o = 1'b1;
    end
  end

  simmem_rr_arbiter #(
    .N(NumSlots)
  ) u_arbiter (
    .req       (expired_vec),
    .ptr       (rr_ptr_q),
    .gnt_onehot(gnt_onehot),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always_comb begin
    for (int i = 0; i < NumSlots; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        SlotIdle: begin
          if (accept && sched_slot_i == SlotWidth'(i)) begin
            if (sched_delay_i == '0) begin
              state_d[i] = SlotExpired;
            end else begin
              state_d[i] = SlotCounting;
              cnt_d[i]   = sched_delay_i;
            end
          end
        end
        SlotCounting: begin
          // Holds at 1 on the final edge instead of wrapping through zero.
          if (cnt_q[i] == DelayWidth'(1)) state_d[i] = SlotExpired;
          else                            cnt_d[i]   = cnt_q[i] - 1'b1;
        end
        SlotExpired: begin
          if (arb_en && gnt_onehot[i]) state_d[i] = SlotGranted;
        end
        SlotGranted: begin
          if (ack && release_en_q[i]) state_d[i] = SlotIdle;
        end
        default: state_d[i] = SlotIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumSlots; i++) begin
        state_q[i] <= SlotIdle;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NumSlots; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // A new grant loads on the same edge that retires the previous one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      release_en_q <= '0;
      rr_ptr_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      if (arb_en) begin
        release_en_q <= gnt_valid ? gnt_onehot : '0;
        if (gnt_valid) begin
          rr_ptr_q <= (gnt_idx == SlotWidth'(NumSlots-1)) ? '0 : gnt_idx + 1'b1;
        end
      end
      if (|(released_onehot_i & ~release_en_q)) err_q <= 1'b1;
    end
  end

  assign release_en_o = release_en_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_simmem_release_scheduler.sv
// Scenario tasks with inline checks, plus a randomized run checked against a
// timestamp-based model of slot expiry and round-robin release.
module tb_simmem_release_scheduler;

  logic        clk;
  logic        rst_n;
  logic        sched_valid;
  logic        sched_ready;
  logic [3:0]  sched_slot;
  logic [7:0]  sched_delay;
  logic [15:0] release_en;
  logic [15:0] released;
  logic [15:0] slot_busy;
  logic        err;

  int n_checks;
  int n_fail;

  // Model: 0 idle, 1 waiting (expires at m_exp), 2 granted.
  int m_st  [16];
  int m_exp [16];
  int m_grant;
  int m_ptr;
  bit m_err;
  int edge_n;

  simmem_release_scheduler dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .sched_valid_i    (sched_valid),
    .sched_ready_o    (sched_ready),
    .sched_slot_i     (sched_slot),
    .sched_delay_i    (sched_delay),
    .release_en_o     (release_en),
    .released_onehot_i(released),
    .slot_busy_o      (slot_busy),
    .err_o            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task tick();
    @(posedge clk);
    #1;
  endtask

  task do_reset();
    rst_n       = 1'b0;
    sched_valid = 1'b0;
    sched_slot  = '0;
    sched_delay = '0;
    released    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task test_reset();
    rst_n       = 1'b0;
    sched_valid = 1'b0;
    sched_slot  = '0;
    sched_delay = '0;
    released    = '0;
    #3;
    n_checks += 4;
    if (release_en !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_release: got %h expected 0000", release_en); end
    if (slot_busy !== 16'h0)  begin n_fail++; $display("[TB] FAIL reset_busy: got %h expected 0000", slot_busy); end
    if (err !== 1'b0)         begin n_fail++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
    if (sched_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b expected 1", sched_ready); end
    do_reset();
  endtask

  task test_single_delay();
    do_reset();
    sched_valid = 1'b1; sched_slot = 4'd3; sched_delay = 8'd4;
    #1;
    n_checks++;
    if (sched_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL single_ready: got %b expected 1", sched_ready); end
    tick();
    sched_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_checks++;
      if (release_en !== 16'h0) begin n_fail++; $display("[TB] FAIL single_early cycle %0d: got %h expected 0000", k, release_en); end
    end
    for (int k = 5; k <= 7; k++) begin
      tick();
      n_checks++;
      if (release_en !== 16'h0008) begin n_fail++; $display("[TB] FAIL single_grant cycle %0d: got %h expected 0008", k, release_en); end
    end
    released = 16'h0008;
    tick();
    released = '0;
    n_checks += 2;
    if (release_en !== 16'h0) begin n_fail++; $display("[TB] FAIL single_after_ack: got %h expected 0000", release_en); end
    if (slot_busy[3] !== 1'b0) begin n_fail++; $display("[TB] FAIL single_busy3: got %b expected 0", slot_busy[3]); end
  endtask

  task test_zero_delay_hold();
    do_reset();
    sched_valid = 1'b1; sched_slot = 4'd0; sched_delay = 8'd0;
    tick();
    sched_valid = 1'b0;
    tick();
    n_checks++;
    if (release_en !== 16'h0001) begin n_fail++; $display("[TB] FAIL zero_first: got %h expected 0001", release_en); end
    for (int k = 0; k < 20; k++) begin
      tick();
      n_checks++;
      if (release_en !== 16'h0001) begin n_fail++; $display("[TB] FAIL zero_hold %0d: got %h expected 0001", k, release_en); end
    end
    released = 16'h0001;
    tick();
    released = '0;
    n_checks++;
    if (release_en !== 16'h0) begin n_fail++; $display("[TB] FAIL zero_ack: got %h expected 0000", release_en); end
  endtask

  task test_rr_order();
    logic [15:0] order [3];
    order[0] = 16'h0004; order[1] = 16'h0020; order[2] = 16'h0002;
    do_reset();
    // A grant of slot 1 leaves the pointer at 2.
    sched_valid = 1'b1; sched_slot = 4'd1; sched_delay = 8'd0;
    tick();
    sched_valid = 1'b0;
    tick();
    n_checks++;
    if (release_en !== 16'h0002) begin n_fail++; $display("[TB] FAIL rr_prep: got %h expected 0002", release_en); end
    released = 16'h0002;
    tick();
    released = '0;
    sched_valid = 1'b1; sched_slot = 4'd1; sched_delay = 8'd5; tick();
    sched_slot = 4'd2; sched_delay = 8'd4; tick();
    sched_slot = 4'd5; sched_delay = 8'd3; tick();
    sched_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (release_en !== 16'h0) begin n_fail++; $display("[TB] FAIL rr_wait %0d: got %h expected 0000", k, release_en); end
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (release_en !== order[k]) begin n_fail++; $display("[TB] FAIL rr_order %0d: got %h expected %h", k, release_en, order[k]); end
      released = order[k];
    end
    tick();
    released = '0;
    n_checks++;
    if (release_en !== 16'h0) begin n_fail++; $display("[TB] FAIL rr_drain: got %h expected 0000", release_en); end
  endtask

  task test_full();
    logic found;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      sched_valid = 1'b1; sched_slot = 4'(i); sched_delay = 8'd255;
      tick();
    end
    sched_valid = 1'b0;
    n_checks++;
    if (slot_busy !== 16'hFFFF) begin n_fail++; $display("[TB] FAIL full_busy: got %h expected ffff", slot_busy); end
    for (int i = 0; i < 16; i++) begin
      sched_slot = 4'(i);
      #1;
      n_checks++;
      if (sched_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL full_ready slot %0d: got %b expected 0", i, sched_ready); end
    end
    found = 1'b0;
    for (int c = 0; c < 600 && !found; c++) begin
      if (release_en === 16'h0080) found = 1'b1;
      else begin
        released = release_en;
        tick();
        released = '0;
      end
    end
    n_checks++;
    if (!found) begin n_fail++; $display("[TB] FAIL full_grant7: got %h expected 0080 within 600 cycles", release_en); end
    sched_slot = 4'd7;
    #1;
    n_checks++;
    if (sched_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL full_ready7_granted: got %b expected 0", sched_ready); end
    released = 16'h0080;
    tick();
    released = '0;
    n_checks++;
    if (sched_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL full_ready7_after: got %b expected 1", sched_ready); end
  endtask

  task test_error();
    do_reset();
    sched_valid = 1'b1; sched_slot = 4'd4; sched_delay = 8'd0; tick();
    sched_slot = 4'd1; sched_delay = 8'd100; tick();
    sched_valid = 1'b0;
    n_checks += 2;
    if (release_en !== 16'h0010) begin n_fail++; $display("[TB] FAIL err_grant4: got %h expected 0010", release_en); end
    if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL err_clean: got %b expected 0", err); end
    released = 16'h0002;
    tick();
    released = '0;
    sched_slot = 4'd1;
    #1;
    n_checks += 4;
    if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL err_set: got %b expected 1", err); end
    if (release_en !== 16'h0010) begin n_fail++; $display("[TB] FAIL err_keep4: got %h expected 0010", release_en); end
    if (slot_busy !== 16'h0012) begin n_fail++; $display("[TB] FAIL err_busy: got %h expected 0012", slot_busy); end
    if (sched_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL err_slot1: got %b expected 0", sched_ready); end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL err_sticky %0d: got %b expected 1", k, err); end
    end
    released = 16'h0010;
    tick();
    released = '0;
    n_checks += 3;
    if (release_en !== 16'h0) begin n_fail++; $display("[TB] FAIL err_ack4: got %h expected 0000", release_en); end
    if (slot_busy !== 16'h0002) begin n_fail++; $display("[TB] FAIL err_busy_after: got %h expected 0002", slot_busy); end
    if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL err_sticky_end: got %b expected 1", err); end
  endtask

  task test_mid_reset();
    do_reset();
    sched_valid = 1'b1; sched_delay = 8'd10;
    sched_slot = 4'd0; tick();
    sched_slot = 4'd5; tick();
    sched_slot = 4'd9; tick();
    sched_valid = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks += 3;
    if (release_en !== 16'h0) begin n_fail++; $display("[TB] FAIL midrst_release: got %h expected 0000", release_en); end
    if (slot_busy !== 16'h0) begin n_fail++; $display("[TB] FAIL midrst_busy: got %h expected 0000", slot_busy); end
    if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_err: got %b expected 0", err); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      n_checks++;
      if (release_en !== 16'h0 || slot_busy !== 16'h0) begin
        n_fail++;
        $display("[TB] FAIL midrst_ghost %0d: got release %h busy %h expected 0000 0000", k, release_en, slot_busy);
      end
    end
  endtask

  task test_random();
    logic [15:0] exp_rel;
    logic [15:0] exp_busy;
    int E;
    int win;
    int j;
    bit ack;
    bit acc;
    do_reset();
    for (int i = 0; i < 16; i++) begin m_st[i] = 0; m_exp[i] = 0; end
    m_grant = -1; m_ptr = 0; m_err = 1'b0; edge_n = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      sched_valid = 1'($urandom_range(0, 1));
      sched_slot  = 4'($urandom_range(0, 15));
      sched_delay = 8'($urandom_range(0, 12));
      released    = '0;
      if (m_grant >= 0 && $urandom_range(0, 9) < 6) released = 16'h1 << m_grant;
      if ($urandom_range(0, 499) == 0) released = released | (16'h1 << $urandom_range(0, 15));
      #1;
      n_checks++;
      if (sched_ready !== 1'(m_st[sched_slot] == 0)) begin
        n_fail++;
        $display("[TB] FAIL rand_ready cyc %0d slot %0d: got %b expected %b", cyc, sched_slot, sched_ready, m_st[sched_slot] == 0);
      end
      // Model: a slot accepted at edge E0 with delay d may win arbitration at any edge after E0+d.
      E   = edge_n + 1;
      acc = sched_valid && (m_st[sched_slot] == 0);
      ack = (m_grant >= 0) && released[m_grant];
      for (int b = 0; b < 16; b++) if (released[b] && b != m_grant) m_err = 1'b1;
      win = -1;
      for (int k = 0; k < 16; k++) begin
        j = (m_ptr + k) % 16;
        if (win < 0 && m_st[j] == 1 && m_exp[j] < E) win = j;
      end
      if (m_grant < 0 || ack) begin
        if (ack) m_st[m_grant] = 0;
        if (win >= 0) begin
          m_st[win] = 2; m_grant = win; m_ptr = (win + 1) % 16;
        end else begin
          m_grant = -1;
        end
      end
      if (acc) begin
        m_st[sched_slot]  = 1;
        m_exp[sched_slot] = E + int'(sched_delay);
      end
      edge_n = E;
      tick();
      exp_rel  = (m_grant >= 0) ? (16'h1 << m_grant) : 16'h0;
      exp_busy = '0;
      for (int i = 0; i < 16; i++) exp_busy[i] = (m_st[i] != 0);
      n_checks += 3;
      if (release_en !== exp_rel) begin n_fail++; $display("[TB] FAIL rand_release cyc %0d: got %h expected %h", cyc, release_en, exp_rel); end
      if (slot_busy !== exp_busy) begin n_fail++; $display("[TB] FAIL rand_busy cyc %0d: got %h expected %h", cyc, slot_busy, exp_busy); end
      if (err !== m_err) begin n_fail++; $display("[TB] FAIL rand_err cyc %0d: got %b expected %b", cyc, err, m_err); end
    end
    released    = '0;
    sched_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single_delay();
    test_zero_delay_hold();
    test_rr_order();
    test_full();
    test_error();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
